// File: rtl/beam_search_ctrl.sv
// Beam-search controller: keeps an L-deep candidate list sorted by distance,
// expands the nearest unchecked vertex, and merges returned neighbours into the list.
module beam_search_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DIST_WIDTH = 32,
    parameter int L          = 8,
    parameter int K          = 5,
    parameter int MAX_ITERS  = 64,
    localparam int IW        = $clog2(MAX_ITERS + 1)
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    start_in,
    input  logic [ADDR_WIDTH-1:0]   entry_addr_in,
    input  logic [DIST_WIDTH-1:0]   entry_dist_in,
    output logic [ADDR_WIDTH-1:0]   fetch_addr_out,
    output logic                    fetch_valid_out,
    input  logic                    fetch_ready_in,
    input  logic [ADDR_WIDTH-1:0]   neigh_addr_in,
    input  logic [DIST_WIDTH-1:0]   neigh_dist_in,
    input  logic                    neigh_last_in,
    input  logic                    neigh_valid_in,
    output logic                    neigh_ready_out,
    output logic [K*ADDR_WIDTH-1:0] top_k_out,
    output logic [K*DIST_WIDTH-1:0] top_k_dist_out,
    output logic [K-1:0]            top_k_valid_out,
    output logic                    valid_out,
    output logic                    busy_out,
    output logic [IW-1:0]           iters_out,
    output logic [2:0]              state
);

    // state   | meaning
    // IDLE    | waiting for start, list holds nothing useful
    // SELECT  | pick nearest unchecked candidate or finish
    // FETCH   | request neighbours of the chosen vertex
    // COLLECT | merge neighbour beats until the last one
    // DONE    | results valid, waiting for the next start
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        FETCH   = 3'd2,
        COLLECT = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [IW-1:0] ITER_CAP = IW'(MAX_ITERS);

    state_t                cur_state, nxt_state;
    logic [ADDR_WIDTH-1:0] slot_addr [L];
    logic [DIST_WIDTH-1:0] slot_dist [L];
    logic [L-1:0]          slot_occ, slot_chk;
    logic [ADDR_WIDTH-1:0] addr_n [L];
    logic [DIST_WIDTH-1:0] dist_n [L];
    logic [L-1:0]          occ_n, chk_n;
    logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_n;
    logic [IW-1:0]         iters_q, iters_n;

    logic sel_found, dup, do_ins;
    int   sel_idx, ins_pos;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cur_state    <= IDLE;
            slot_addr    <= '{default: '0};
            slot_dist    <= '{default: '1};
            slot_occ     <= '0;
            slot_chk     <= '0;
            fetch_addr_q <= '0;
            iters_q      <= '0;
        end else begin
            cur_state    <= nxt_state;
            slot_addr    <= addr_n;
            slot_dist    <= dist_n;
            slot_occ     <= occ_n;
            slot_chk     <= chk_n;
            fetch_addr_q <= fetch_addr_n;
            iters_q      <= iters_n;
        end
    end

    always_comb begin
        nxt_state    = cur_state;
        addr_n       = slot_addr;
        dist_n       = slot_dist;
        occ_n        = slot_occ;
        chk_n        = slot_chk;
        fetch_addr_n = fetch_addr_q;
        iters_n      = iters_q;

        // Descending scan leaves the lowest-index unchecked slot selected
        sel_found = 1'b0;
        sel_idx   = 0;
        for (int i = L - 1; i >= 0; i--) begin
            if (slot_occ[i] && !slot_chk[i]) begin
                sel_found = 1'b1;
                sel_idx   = i;
            end
        end

        // Insertion point counts ties as "before", so equal distances keep arrival order
        dup     = 1'b0;
        ins_pos = 0;
        for (int i = 0; i < L; i++) begin
            if (slot_occ[i] && slot_addr[i] == neigh_addr_in) dup = 1'b1;
            if (slot_occ[i] && slot_dist[i] <= neigh_dist_in) ins_pos = ins_pos + 1;
        end
        do_ins = !dup && (!slot_occ[L-1] || neigh_dist_in < slot_dist[L-1]);

        case (cur_state)
            IDLE, DONE: begin
                if (start_in) begin
                    addr_n    = '{default: '0};
                    dist_n    = '{default: '1};
                    occ_n     = '0;
                    chk_n     = '0;
                    addr_n[0] = entry_addr_in;
                    dist_n[0] = entry_dist_in;
                    occ_n[0]  = 1'b1;
                    iters_n   = '0;
                    nxt_state = SELECT;
                end
            end
            SELECT: begin
                if (iters_q == ITER_CAP || !sel_found) begin
                    nxt_state = DONE;
                end else begin
                    for (int i = 0; i < L; i++) begin
                        if (i == sel_idx) begin
                            chk_n[i]     = 1'b1;
                            fetch_addr_n = slot_addr[i];
                        end
                    end
                    iters_n   = iters_q + IW'(1);
                    nxt_state = FETCH;
                end
            end
            FETCH: begin
                if (fetch_ready_in) nxt_state = COLLECT;
            end
            COLLECT: begin
                if (neigh_valid_in) begin
                    if (do_ins) begin
                        for (int i = 1; i < L; i++) begin
                            if (i > ins_pos) begin
                                addr_n[i] = slot_addr[i-1];
                                dist_n[i] = slot_dist[i-1];
                                occ_n[i]  = slot_occ[i-1];
                                chk_n[i]  = slot_chk[i-1];
                            end
                        end
                        for (int i = 0; i < L; i++) begin
                            if (i == ins_pos) begin
                                addr_n[i] = neigh_addr_in;
                                dist_n[i] = neigh_dist_in;
                                occ_n[i]  = 1'b1;
                                chk_n[i]  = 1'b0;
                            end
                        end
                    end
                    if (neigh_last_in) nxt_state = SELECT;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    assign fetch_addr_out  = fetch_addr_q;
    assign fetch_valid_out = (cur_state == FETCH);
    assign neigh_ready_out = (cur_state == COLLECT);
    assign busy_out        = (cur_state == SELECT) || (cur_state == FETCH) || (cur_state == COLLECT);
    assign valid_out       = (cur_state == DONE);
    assign iters_out       = iters_q;
    assign state           = cur_state;

    for (genvar k = 0; k < K; k++) begin : g_topk
        assign top_k_out[k*ADDR_WIDTH +: ADDR_WIDTH]      = slot_addr[k];
        assign top_k_dist_out[k*DIST_WIDTH +: DIST_WIDTH] = slot_dist[k];
        assign top_k_valid_out[k]                         = slot_occ[k];
    end

endmodule

// File: tb/tb_beam_search_ctrl.sv
// Directed bench for beam_search_ctrl: default list, a 4-deep list for overflow/tie
// ordering, and a 2-iteration cap instance, all sharing one stimulus bus.
module tb_beam_search_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, fetch_ready, n_last, n_valid;
    logic [31:0] entry_addr, entry_dist, n_addr, n_dist;
    int          sel;
    int          n_checks = 0;
    int          n_errors = 0;
    int          fetch_cnt;

    logic [31:0]  d0_fa, d1_fa, d2_fa;
    logic         d0_fv, d1_fv, d2_fv, d0_nr, d1_nr, d2_nr;
    logic         d0_valid, d1_valid, d2_valid, d0_busy, d1_busy, d2_busy;
    logic [159:0] d0_tk, d0_td, d2_tk, d2_td;
    logic [127:0] d1_tk, d1_td;
    logic [4:0]   d0_tv, d2_tv;
    logic [3:0]   d1_tv;
    logic [6:0]   d0_it, d1_it;
    logic [1:0]   d2_it;
    logic [2:0]   d0_st, d1_st, d2_st;

    beam_search_ctrl u_dut0 (
        .clk_in(clk), .rst_in(rst), .start_in(start),
        .entry_addr_in(entry_addr), .entry_dist_in(entry_dist),
        .fetch_addr_out(d0_fa), .fetch_valid_out(d0_fv), .fetch_ready_in(fetch_ready),
        .neigh_addr_in(n_addr), .neigh_dist_in(n_dist), .neigh_last_in(n_last),
        .neigh_valid_in(n_valid), .neigh_ready_out(d0_nr),
        .top_k_out(d0_tk), .top_k_dist_out(d0_td), .top_k_valid_out(d0_tv),
        .valid_out(d0_valid), .busy_out(d0_busy), .iters_out(d0_it), .state(d0_st)
    );

    beam_search_ctrl #(.L(4), .K(4)) u_dut1 (
        .clk_in(clk), .rst_in(rst), .start_in(start),
        .entry_addr_in(entry_addr), .entry_dist_in(entry_dist),
        .fetch_addr_out(d1_fa), .fetch_valid_out(d1_fv), .fetch_ready_in(fetch_ready),
        .neigh_addr_in(n_addr), .neigh_dist_in(n_dist), .neigh_last_in(n_last),
        .neigh_valid_in(n_valid), .neigh_ready_out(d1_nr),
        .top_k_out(d1_tk), .top_k_dist_out(d1_td), .top_k_valid_out(d1_tv),
        .valid_out(d1_valid), .busy_out(d1_busy), .iters_out(d1_it), .state(d1_st)
    );

    beam_search_ctrl #(.MAX_ITERS(2)) u_dut2 (
        .clk_in(clk), .rst_in(rst), .start_in(start),
        .entry_addr_in(entry_addr), .entry_dist_in(entry_dist),
        .fetch_addr_out(d2_fa), .fetch_valid_out(d2_fv), .fetch_ready_in(fetch_ready),
        .neigh_addr_in(n_addr), .neigh_dist_in(n_dist), .neigh_last_in(n_last),
        .neigh_valid_in(n_valid), .neigh_ready_out(d2_nr),
        .top_k_out(d2_tk), .top_k_dist_out(d2_td), .top_k_valid_out(d2_tv),
        .valid_out(d2_valid), .busy_out(d2_busy), .iters_out(d2_it), .state(d2_st)
    );

    logic        fv_sel, nr_sel;
    logic [31:0] fa_sel;
    logic [2:0]  st_sel;
    assign fv_sel = (sel == 0) ? d0_fv : (sel == 1) ? d1_fv : d2_fv;
    assign nr_sel = (sel == 0) ? d0_nr : (sel == 1) ? d1_nr : d2_nr;
    assign fa_sel = (sel == 0) ? d0_fa : (sel == 1) ? d1_fa : d2_fa;
    assign st_sel = (sel == 0) ? d0_st : (sel == 1) ? d1_st : d2_st;

    always @(posedge clk) begin
        if (rst) fetch_cnt <= 0;
        else if (d2_fv && fetch_ready) fetch_cnt <= fetch_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic do_start(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        start = 1'b1; entry_addr = a; entry_dist = d;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_fetch(input string tag, input logic [31:0] expa, input int hold);
        int n = 0;
        bit stable = 1'b1;
        while (!fv_sel && n < 50) begin @(negedge clk); n++; end
        check_val({tag, "_seen"}, fv_sel, 1);
        check_val({tag, "_addr"}, fa_sel, expa);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!fv_sel || fa_sel !== expa) stable = 1'b0;
        end
        if (hold > 0) check_val({tag, "_hold"}, stable, 1);
        fetch_ready = 1'b1;
        @(negedge clk);
        fetch_ready = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] a, input logic [31:0] d, input logic last);
        int n = 0;
        n_addr = a; n_dist = d; n_last = last; n_valid = 1'b1;
        while (!nr_sel && n < 50) begin @(negedge clk); n++; end
        if (!nr_sel) check_val("beat_ready", nr_sel, 1);
        @(negedge clk);
        n_valid = 1'b0; n_last = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (st_sel != 3'd4 && n < 100) begin @(negedge clk); n++; end
        check_val(tag, st_sel, 4);
    endtask

    initial begin
        bit quiet;
        rst = 1'b1; start = 1'b0; fetch_ready = 1'b0; n_valid = 1'b0; n_last = 1'b0;
        entry_addr = '0; entry_dist = '0; n_addr = '0; n_dist = '0; sel = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset values, then idle with no start
        check_val("rst_state", d0_st, 0);
        check_val("rst_valid", d0_valid, 0);
        check_val("rst_busy", d0_busy, 0);
        check_val("rst_fv", d0_fv, 0);
        check_val("rst_nr", d0_nr, 0);
        check_val("rst_faddr", d0_fa, 0);
        check_val("rst_iters", d0_it, 0);
        check_val("rst_topk", d0_tk, 0);
        check_val("rst_topd", d0_td, {160{1'b1}});
        check_val("rst_topv", d0_tv, 0);
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (d0_fv || d0_st != 3'd0) quiet = 1'b0;
        end
        check_val("idle_quiet", quiet, 1);

        // single-expansion search, L=8 K=5
        do_start(32'd10, 32'd50);
        check_val("t1_select", d0_st, 1);
        check_val("t1_busy", d0_busy, 1);
        @(negedge clk);
        check_val("t1_fetch_state", d0_st, 2);
        check_val("t1_fv_rise", d0_fv, 1);
        check_val("t1_nr_fetch", d0_nr, 0);
        do_fetch("f1", 32'd10, 0);
        send_beat(32'd3, 32'd20, 1'b0);
        send_beat(32'd7, 32'd80, 1'b0);
        send_beat(32'd4, 32'd30, 1'b1);
        check_val("t1_list_k", d0_tk, {32'd0, 32'd7, 32'd10, 32'd4, 32'd3});
        check_val("t1_list_d", d0_td, {32'hFFFF_FFFF, 32'd80, 32'd50, 32'd30, 32'd20});
        do_fetch("f2", 32'd3, 10);
        send_beat(32'd10, 32'd1, 1'b0);
        check_val("dup_k", d0_tk, {32'd0, 32'd7, 32'd10, 32'd4, 32'd3});
        check_val("dup_d", d0_td, {32'hFFFF_FFFF, 32'd80, 32'd50, 32'd30, 32'd20});
        send_beat(32'd3, 32'd99, 1'b1);
        do_fetch("f3", 32'd4, 0);
        send_beat(32'd7, 32'd99, 1'b1);
        do_fetch("f4", 32'd7, 0);
        send_beat(32'd3, 32'd99, 1'b1);
        wait_done("t1_done");
        check_val("t1_iters", d0_it, 4);
        check_val("t1_valid", d0_valid, 1);
        check_val("t1_busy_done", d0_busy, 0);
        check_val("t1_topk", d0_tk, {32'd0, 32'd7, 32'd10, 32'd4, 32'd3});
        check_val("t1_topv", d0_tv, 5'b01111);

        // overflow and tie ordering, L=4
        rst = 1'b1; @(negedge clk); rst = 1'b0; sel = 1;
        do_start(32'd1, 32'd5);
        do_fetch("o1", 32'd1, 0);
        send_beat(32'd2, 32'd9, 1'b0);
        send_beat(32'd3, 32'd9, 1'b0);
        send_beat(32'd4, 32'd2, 1'b0);
        check_val("ov_full_k", d1_tk, {32'd3, 32'd2, 32'd1, 32'd4});
        check_val("ov_full_v", d1_tv, 4'b1111);
        send_beat(32'd5, 32'd9, 1'b0);
        check_val("ov_tie_drop", d1_tk, {32'd3, 32'd2, 32'd1, 32'd4});
        send_beat(32'd6, 32'd1, 1'b1);
        check_val("ov_final_k", d1_tk, {32'd2, 32'd1, 32'd4, 32'd6});
        check_val("ov_final_d", d1_td, {32'd9, 32'd5, 32'd2, 32'd1});

        // reset while collecting
        do_fetch("o2", 32'd6, 0);
        check_val("ab_collect", d1_st, 3);
        rst = 1'b1;
        @(negedge clk);
        check_val("ab_state", d1_st, 0);
        check_val("ab_nr", d1_nr, 0);
        check_val("ab_fv", d1_fv, 0);
        check_val("ab_topv", d1_tv, 0);
        check_val("ab_iters", d1_it, 0);
        rst = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (d1_fv || d1_nr) quiet = 1'b0;
        end
        check_val("ab_quiet", quiet, 1);

        // iteration cap of 2
        rst = 1'b1; @(negedge clk); rst = 1'b0; sel = 2;
        do_start(32'd100, 32'd50);
        do_fetch("c1", 32'd100, 0);
        send_beat(32'd101, 32'd40, 1'b1);
        do_fetch("c2", 32'd101, 0);
        send_beat(32'd102, 32'd30, 1'b1);
        wait_done("cap_done");
        check_val("cap_iters", d2_it, 2);
        check_val("cap_fetches", fetch_cnt, 2);
        check_val("cap_top0", d2_tk[31:0], 32'd102);
        check_val("cap_topv", d2_tv, 5'b00111);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
